// File: rtl/serial_word_shifter.sv
// Parallel-to-serial word shifter with a one-word skid buffer.
// Words accepted over valid/ready are shifted out one bit per bit_en strobe.
// A held word reloads on the last-bit edge, so consecutive words form a gap-free stream.
module serial_word_shifter #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done,
    busy
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;
    logic [WIDTH-1:0] sr_shifted;

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            hold_data_q  <= '0;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            hold_data_q  <= hold_data_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: skid-buffer accept, load/reload of the shifter, bit consumption
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        hold_data_d  = hold_data_q;
        hold_full_d  = hold_full_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        accept     = din_valid && !hold_full_q;
        sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

        // Accept needs the hold register empty; loads below need it full, so they never collide
        if (accept) begin
            hold_data_d = din;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    sr_d        = hold_data_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_en) begin
                    if (cnt_q == CNT_LAST) begin
                        frame_done_d = 1'b1;
                        if (hold_full_q) begin
                            sr_d        = hold_data_q;
                            cnt_d       = '0;
                            hold_full_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sr_d  = sr_shifted;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only; no path from din to sout
    assign din_ready  = !hold_full_q;
    assign sout_valid = (state_q == ST_SHIFT);
    assign sout       = (state_q == ST_SHIFT) ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_LEVEL;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_SHIFT) || hold_full_q;

endmodule

// File: doc/serial_word_shifter.md
# serial_word_shifter

Parallel-to-serial front end for the FSM run-detector path. Accepts WIDTH-bit words over a valid/ready handshake, holds up to one pending word in a skid buffer, and shifts each word out one bit per bit-strobe so that back-to-back words form a gap-free serial stream. Its `sout` drives the serial `in` of the Mealy run-pattern detector, and `sout_valid` qualifies that stream.

## Interface
- WIDTH, 8: word width in bits, at least 2.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_LEVEL, 1'b0: value driven on `sout` when no word is shifting.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nRESET  input  1  reset; asynchronous, active-low.
- din  input  WIDTH  parallel word.
- din_valid  input  1  `din` is presented.
- din_ready  output  1  combinational, equal to !hold_full; a word transfers on a rising edge where din_valid && din_ready.
- bit_en  input  1  bit-rate strobe; the current bit is consumed on a rising edge where bit_en=1 in SHIFT.
- sout  output  1  current serial bit.
- sout_valid  output  1  high while in SHIFT.
- frame_done  output  1  one-cycle pulse after the last bit of a word is consumed.
- busy  output  1  SHIFT || hold_full.

## Operation
- Storage:
  - hold register `hold_data`/`hold_full`;
  - shift register `sr` (WIDTH bits);
  - bit counter `cnt` (ceil(log2 WIDTH) bits, counts 0..WIDTH-1);
  - state register (IDLE, SHIFT).
- Accept: on a transfer, `hold_data` <= din and `hold_full` <= 1. Accept and load never coincide, because accept needs the hold register empty and load needs it full.
- IDLE:
  - If hold_full: load `sr` <= hold_data, cnt <= 0, hold_full <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT with bit_en=0: hold all state; `sout` stays stable.
- SHIFT with bit_en=1 and cnt < WIDTH-1:
  - shift `sr` by one toward the output end (left if MSB_FIRST, right otherwise);
  - fill the vacated bit with 0;
  - cnt <= cnt+1.
- SHIFT with bit_en=1 and cnt = WIDTH-1 (last bit):
  - frame_done <= 1 for one cycle;
  - if hold_full: reload `sr` from hold, cnt <= 0, hold_full <= 0, stay in SHIFT (no idle bit between words);
  - otherwise go to IDLE.
- Output:
  - `sout` = sr[WIDTH-1] if MSB_FIRST, else sr[0], while in SHIFT;
  - `sout` = IDLE_LEVEL in IDLE.
- Reset values, applied immediately and asynchronously on nRESET low:
  - state IDLE, sr = 0, cnt = 0, hold_full = 0, hold_data = 0;
  - sout = IDLE_LEVEL, sout_valid = 0, frame_done = 0, busy = 0;
  - din_ready = 1 combinationally, but no transfer is captured while nRESET is low.
- Reset mid-operation: the in-flight word and the held word are both discarded; no frame_done is emitted for either.
- din_valid while din_ready=0: ignored. The source must hold the word until ready.

## Timing
- Word accepted at edge N with the block idle:
  - load at edge N+1;
  - first bit valid on `sout` after edge N+1;
  - din_ready returns high after edge N+1.
- With bit_en tied high, a word occupies exactly WIDTH cycles of sout_valid.
- Each bit is held on `sout` until the edge at which bit_en is sampled high.
- frame_done is registered and high for the cycle after the last-bit edge, coincident with either the first bit of the next word or sout_valid=0.
- Sustained streaming with bit_en=1 needs one accepted word per WIDTH cycles. Any source meeting that keeps sout_valid continuously high.
- No combinational path from din/din_valid to sout/sout_valid.

## Test plan
- Single word, MSB first: WIDTH=8, MSB_FIRST=1, bit_en=1, din=8'hF0.
  - sout = 1,1,1,1,0,0,0,0 on the 8 cycles after load, with sout_valid=1 throughout;
  - frame_done pulses once;
  - then sout=0 (IDLE_LEVEL) and sout_valid=0.
- Back-to-back words: 8'h0F then 8'hA5.
  - 16 contiguous valid bits, 0000_1111_1010_0101, with no idle cycle;
  - two frame_done pulses 8 cycles apart;
  - din_ready low from second accept until second load.
- Slow strobe: bit_en high every 3rd cycle, din=8'h81.
  - each bit held exactly 3 cycles;
  - frame_done 24±2 cycles after load.
- Backpressure: present three words with din_valid held high.
  - the third word is not taken until the first word's last-bit edge reloads from hold;
  - no word is lost or duplicated.
- LSB first: MSB_FIRST=0, din=8'h01 → sout = 1,0,0,0,0,0,0,0.
- Reset mid-frame: assert nRESET after 3 bits of 8'hFF with a word held.
  - sout_valid=0, busy=0, sout=IDLE_LEVEL immediately;
  - no frame_done;
  - after release, a new word 8'h00 shifts out normally.
- Integration: feed 8'h00 into the run detector → detector `out`=1 on the 2nd, 3rd and 4th zero bits.
